// File: rtl/mips_mc_ctrl.sv
// ALU operation codes shared with the ALU, and the multicycle MIPS control FSM
// that sequences fetch/decode/execute/memory/writeback and drives every datapath enable and select.
package alu_pkg;
    typedef enum logic [4:0] {
        C_NOP, C_ADD_U, C_SUB_U, C_AND, C_OR, C_XOR, C_SLL, C_SRL, C_SRA,
        C_SLT, C_SLTU, C_MULT, C_MUL_U, C_BEQ, C_BNE, C_BLEZ, C_BGTZ, C_BLTZ, C_BGEZ
    } alu_sel_t;
endpackage

module mips_mc_ctrl
    import alu_pkg::*;
#(
    parameter int RA_IDX = 31
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [5:0]     i_ir_op,
    input  logic [5:0]     i_ir_funct,
    input  logic [4:0]     i_ir_rt,
    input  logic           i_mem_ready,
    input  logic           i_branch_taken,
    output alu_sel_t       o_opsel,
    output logic           o_src_a,
    output logic [1:0]     o_src_b,
    output logic           o_imm_zext,
    output logic           o_iord,
    output logic           o_mem_rd,
    output logic           o_mem_wr,
    output logic           o_ir_wr,
    output logic           o_pc_en,
    output logic [1:0]     o_pc_src,
    output logic           o_reg_wr,
    output logic [1:0]     o_reg_dst,
    output logic [1:0]     o_wb_sel,
    output logic [1:0]     o_alu_lo_hi,
    output logic           o_hi_en,
    output logic           o_lo_en,
    output logic           o_halted,
    output logic [3:0]     o_dbg_state
);

    // The datapath consumes RA_IDX when reg_dst selects the link register.
    if (RA_IDX < 0 || RA_IDX > 31) begin : g_bad_ra_idx
        $error("RA_IDX must be a valid register index");
    end

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_LD, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t r_state, w_next;

    assign o_dbg_state = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_opsel     = C_NOP;
        o_src_a     = 1'b0;
        o_src_b     = 2'd0;
        o_imm_zext  = 1'b0;
        o_iord      = 1'b0;
        o_mem_rd    = 1'b0;
        o_mem_wr    = 1'b0;
        o_ir_wr     = 1'b0;
        o_pc_en     = 1'b0;
        o_pc_src    = 2'd0;
        o_reg_wr    = 1'b0;
        o_reg_dst   = 2'd0;
        o_wb_sel    = 2'd0;
        o_alu_lo_hi = 2'd0;
        o_hi_en     = 1'b0;
        o_lo_en     = 1'b0;
        o_halted    = 1'b0;
        // Outputs stay quiet while reset is held, even though the state already reads FETCH.
        if (i_rst_n) begin
            unique case (r_state)
                S_FETCH: begin
                    o_mem_rd = 1'b1;
                    o_src_b  = 2'd1;
                    o_opsel  = C_ADD_U;
                    o_ir_wr  = i_mem_ready;
                    o_pc_en  = i_mem_ready;
                    if (i_mem_ready) w_next = S_DECODE;
                end
                S_DECODE: begin
                    o_src_b = 2'd3;
                    o_opsel = C_ADD_U;
                    case (i_ir_op)
                        6'h00:                      w_next = S_EXEC_R;
                        6'h23, 6'h2B:               w_next = S_ADDR;
                        6'h01, 6'h04, 6'h05,
                        6'h06, 6'h07:               w_next = S_BRANCH;
                        6'h02, 6'h03:               w_next = S_JUMP;
                        6'h09, 6'h0A, 6'h0B,
                        6'h0C, 6'h0D, 6'h0E:        w_next = S_EXEC_I;
                        6'h3F:                      w_next = S_HALT;
                        default:                    w_next = S_FETCH;
                    endcase
                end
                S_EXEC_R: begin
                    o_src_a = 1'b1;
                    w_next  = S_WB_R;
                    case (i_ir_funct)
                        6'h21: o_opsel = C_ADD_U;
                        6'h23: o_opsel = C_SUB_U;
                        6'h24: o_opsel = C_AND;
                        6'h25: o_opsel = C_OR;
                        6'h26: o_opsel = C_XOR;
                        6'h00: o_opsel = C_SLL;
                        6'h02: o_opsel = C_SRL;
                        6'h03: o_opsel = C_SRA;
                        6'h2A: o_opsel = C_SLT;
                        6'h2B: o_opsel = C_SLTU;
                        6'h10, 6'h12: ;
                        6'h18, 6'h19: begin
                            o_opsel = (i_ir_funct == 6'h18) ? C_MULT : C_MUL_U;
                            o_hi_en = 1'b1;
                            o_lo_en = 1'b1;
                            w_next  = S_FETCH;
                        end
                        6'h08: begin
                            o_pc_en = 1'b1;
                            w_next  = S_FETCH;
                        end
                        default: w_next = S_FETCH;
                    endcase
                end
                S_WB_R: begin
                    o_reg_wr  = 1'b1;
                    o_reg_dst = 2'd1;
                    if (i_ir_funct == 6'h10)      o_alu_lo_hi = 2'd2;
                    else if (i_ir_funct == 6'h12) o_alu_lo_hi = 2'd1;
                    w_next = S_FETCH;
                end
                S_EXEC_I: begin
                    o_src_a = 1'b1;
                    o_src_b = 2'd2;
                    case (i_ir_op)
                        6'h09:   o_opsel = C_ADD_U;
                        6'h0A:   o_opsel = C_SLT;
                        6'h0B:   o_opsel = C_SLTU;
                        6'h0C:   o_opsel = C_AND;
                        6'h0D:   o_opsel = C_OR;
                        6'h0E:   o_opsel = C_XOR;
                        default: o_opsel = C_NOP;
                    endcase
                    o_imm_zext = (i_ir_op >= 6'h0C) && (i_ir_op <= 6'h0E);
                    w_next     = S_WB_I;
                end
                S_WB_I: begin
                    o_reg_wr = 1'b1;
                    w_next   = S_FETCH;
                end
                S_ADDR: begin
                    o_src_a = 1'b1;
                    o_src_b = 2'd2;
                    o_opsel = C_ADD_U;
                    w_next  = (i_ir_op == 6'h23) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    o_iord   = 1'b1;
                    o_mem_rd = 1'b1;
                    if (i_mem_ready) w_next = S_WB_LD;
                end
                S_MEM_WR: begin
                    o_iord   = 1'b1;
                    o_mem_wr = 1'b1;
                    if (i_mem_ready) w_next = S_FETCH;
                end
                S_WB_LD: begin
                    o_reg_wr = 1'b1;
                    o_wb_sel = 2'd1;
                    w_next   = S_FETCH;
                end
                S_BRANCH: begin
                    o_src_a  = 1'b1;
                    o_pc_src = 2'd1;
                    case (i_ir_op)
                        6'h04: o_opsel = C_BEQ;
                        6'h05: o_opsel = C_BNE;
                        6'h06: o_opsel = C_BLEZ;
                        6'h07: o_opsel = C_BGTZ;
                        6'h01: begin
                            if (i_ir_rt == 5'd0)      o_opsel = C_BLTZ;
                            else if (i_ir_rt == 5'd1) o_opsel = C_BGEZ;
                        end
                        default: o_opsel = C_NOP;
                    endcase
                    // An unsupported REGIMM variant never redirects the PC.
                    o_pc_en = i_branch_taken && (o_opsel != C_NOP);
                    w_next  = S_FETCH;
                end
                S_JUMP: begin
                    o_pc_src = 2'd2;
                    o_pc_en  = 1'b1;
                    if (i_ir_op == 6'h03) begin
                        o_reg_wr  = 1'b1;
                        o_reg_dst = 2'd2;
                        o_wb_sel  = 2'd2;
                    end
                    w_next = S_FETCH;
                end
                S_HALT: o_halted = 1'b1;
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class cycle by cycle
// against hand-derived control words.
module tb_mips_mc_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] ir_op, ir_funct;
    logic [4:0] ir_rt;
    logic       mem_ready, branch_taken;
    alu_sel_t   opsel;
    logic       src_a, imm_zext, iord, mem_rd, mem_wr, ir_wr, pc_en;
    logic       reg_wr, hi_en, lo_en, halted;
    logic [1:0] src_b, pc_src, reg_dst, wb_sel, alu_lo_hi;
    logic [3:0] dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.RA_IDX(31)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ir_op(ir_op), .i_ir_funct(ir_funct),
        .i_ir_rt(ir_rt), .i_mem_ready(mem_ready), .i_branch_taken(branch_taken),
        .o_opsel(opsel), .o_src_a(src_a), .o_src_b(src_b), .o_imm_zext(imm_zext),
        .o_iord(iord), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_ir_wr(ir_wr),
        .o_pc_en(pc_en), .o_pc_src(pc_src), .o_reg_wr(reg_wr), .o_reg_dst(reg_dst),
        .o_wb_sel(wb_sel), .o_alu_lo_hi(alu_lo_hi), .o_hi_en(hi_en), .o_lo_en(lo_en),
        .o_halted(halted), .o_dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ir_op = '0; ir_funct = '0; ir_rt = '0;
        mem_ready = 1'b0; branch_taken = 1'b0;
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_opsel", opsel, C_NOP);
        chk("rst_halted", halted, 0);
        tick();
        chk("rst_hold_mem_rd", mem_rd, 0);

        rst_n = 1'b1; #1;
        chk("fetch_mem_rd", mem_rd, 1);
        chk("fetch_pc_en_wait", pc_en, 0);
        chk("fetch_src_b", src_b, 1);
        chk("fetch_opsel", opsel, C_ADD_U);
        tick();
        chk("fetch_stall_mem_rd", mem_rd, 1);
        chk("fetch_stall_ir_wr", ir_wr, 0);

        // ADDU
        ir_op = 6'h00; ir_funct = 6'h21; mem_ready = 1'b1; #1;
        chk("addu_c1_pc_en", pc_en, 1);
        chk("addu_c1_ir_wr", ir_wr, 1);
        tick();
        chk("addu_c2_src_b", src_b, 3);
        chk("addu_c2_pc_en", pc_en, 0);
        tick();
        chk("addu_c3_opsel", opsel, C_ADD_U);
        chk("addu_c3_src_a", src_a, 1);
        chk("addu_c3_reg_wr", reg_wr, 0);
        tick();
        chk("addu_c4_reg_wr", reg_wr, 1);
        chk("addu_c4_reg_dst", reg_dst, 1);
        chk("addu_c4_lohi", alu_lo_hi, 0);
        tick();
        chk("addu_c5_fetch", mem_rd, 1);

        // LW with three wait cycles in the memory read
        ir_op = 6'h23; tick(); tick();
        chk("lw_addr_src_b", src_b, 2);
        chk("lw_addr_opsel", opsel, C_ADD_U);
        mem_ready = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait_mem_rd", mem_rd, 1);
            chk("lw_wait_iord", iord, 1);
            chk("lw_wait_reg_wr", reg_wr, 0);
            tick();
        end
        mem_ready = 1'b1; #1;
        chk("lw_done_mem_rd", mem_rd, 1);
        chk("lw_done_iord", iord, 1);
        tick();
        chk("lw_wb_reg_wr", reg_wr, 1);
        chk("lw_wb_sel", wb_sel, 1);
        chk("lw_wb_reg_dst", reg_dst, 0);
        chk("lw_wb_mem_rd", mem_rd, 0);
        tick();
        chk("lw_back_fetch", mem_rd, 1);
        chk("lw_back_iord", iord, 0);

        // Reset in the middle of a load's memory read
        tick(); tick(); mem_ready = 1'b0; tick();
        chk("midrst_pre_iord", iord, 1);
        rst_n = 1'b0; #1;
        chk("midrst_mem_rd", mem_rd, 0);
        chk("midrst_iord", iord, 0);
        chk("midrst_reg_wr", reg_wr, 0);
        tick();
        rst_n = 1'b1; #1;
        chk("midrst_fetch_mem_rd", mem_rd, 1);
        chk("midrst_fetch_iord", iord, 0);
        chk("midrst_fetch_pc_en", pc_en, 0);
        mem_ready = 1'b1;

        // BEQ taken, then not taken in the same cycle
        ir_op = 6'h04; branch_taken = 1'b1; tick(); tick();
        chk("beq_opsel", opsel, C_BEQ);
        chk("beq_pc_en", pc_en, 1);
        chk("beq_pc_src", pc_src, 1);
        branch_taken = 1'b0; #1;
        chk("beq_nt_pc_en", pc_en, 0);
        tick();
        chk("beq_back_fetch", mem_rd, 1);

        // REGIMM with unsupported rt never redirects, rt=1 is BGEZ
        ir_op = 6'h01; ir_rt = 5'd2; branch_taken = 1'b1; tick(); tick();
        chk("regimm_bad_opsel", opsel, C_NOP);
        chk("regimm_bad_pc_en", pc_en, 0);
        tick();
        ir_rt = 5'd1; tick(); tick();
        chk("bgez_opsel", opsel, C_BGEZ);
        chk("bgez_pc_en", pc_en, 1);
        branch_taken = 1'b0; tick();

        // MULT then MFHI
        ir_op = 6'h00; ir_funct = 6'h18; tick(); tick();
        chk("mult_opsel", opsel, C_MULT);
        chk("mult_hi_en", hi_en, 1);
        chk("mult_lo_en", lo_en, 1);
        chk("mult_reg_wr", reg_wr, 0);
        tick();
        chk("mult_after_hi_en", hi_en, 0);
        chk("mult_after_fetch", mem_rd, 1);
        ir_funct = 6'h10; tick(); tick();
        chk("mfhi_ex_hi_en", hi_en, 0);
        tick();
        chk("mfhi_wb_lohi", alu_lo_hi, 2);
        chk("mfhi_wb_reg_wr", reg_wr, 1);
        tick();

        // ORI zero-extends its immediate
        ir_op = 6'h0D; tick(); tick();
        chk("ori_opsel", opsel, C_OR);
        chk("ori_zext", imm_zext, 1);
        chk("ori_src_b", src_b, 2);
        tick();
        chk("ori_wb_reg_wr", reg_wr, 1);
        chk("ori_wb_reg_dst", reg_dst, 0);
        tick();

        // SW
        ir_op = 6'h2B; tick(); tick(); tick();
        chk("sw_mem_wr", mem_wr, 1);
        chk("sw_mem_rd", mem_rd, 0);
        tick();
        chk("sw_back_fetch", mem_rd, 1);

        // JAL
        ir_op = 6'h03; tick(); tick();
        chk("jal_pc_src", pc_src, 2);
        chk("jal_pc_en", pc_en, 1);
        chk("jal_reg_dst", reg_dst, 2);
        chk("jal_wb_sel", wb_sel, 2);
        chk("jal_reg_wr", reg_wr, 1);
        tick();

        // HALT is terminal
        ir_op = 6'h3F; tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("halt_halted", halted, 1);
            chk("halt_mem_rd", mem_rd, 0);
            chk("halt_pc_en", pc_en, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
